obi_instr_mem_responder: RTL and testbench



---
 rtl/obi_instr_mem_responder_pkg.sv | 30 +++
 rtl/obi_instr_mem_responder_if.sv | 30 +++
 rtl/obi_instr_mem_responder_fifo.sv | 79 +++++++
 rtl/obi_instr_mem_responder.sv | 132 +++++++++++++
 tb/tb_obi_instr_mem_responder.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_instr_mem_responder_pkg.sv
// Shared types and helpers for the OBI instruction-side memory responder.
// The queue entry, stall LFSR taps and the address window check live here.
package obi_resp_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [2:0]  age;
   } resp_entry_t;

   typedef struct packed {
      logic        valid;
      logic [29:0] idx;
   } range_t;

   // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic range_t in_range(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] words
   );
      range_t r;
      r.idx   = 30'((addr - base) >> 2);
      r.valid = (addr >= base) && ({2'b00, r.idx} < words);
      return r;
   endfunction

endpackage

// File: rtl/obi_instr_mem_responder_if.sv
// OBI instruction fetch bus between the core (master) and memory (slave).
// There is no rready: the initiator always accepts rvalid.
interface obi_instr_mem_responder_if;

   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;

   modport master (
      output instr_req_i,
      output instr_addr_i,
      input  instr_gnt_o,
      input  instr_rvalid_o,
      input  instr_rdata_o,
      input  instr_err_o
   );

   modport slave (
      input  instr_req_i,
      input  instr_addr_i,
      output instr_gnt_o,
      output instr_rvalid_o,
      output instr_rdata_o,
      output instr_err_o
   );

endinterface

// File: rtl/obi_instr_mem_responder_fifo.sv
// In-order response queue with per-entry age countdown; the head is
// ready when its age is about to reach 0, so the owner can register rvalid.
module obi_resp_fifo
   import obi_resp_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  resp_entry_t push_entry_i,
   input  logic        pop_i,
   output logic        head_ready_o,
   output resp_entry_t head_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   resp_entry_t   ent_q [DEPTH];
   resp_entry_t   ent_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bypass;
   logic          store;
   logic          deq;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      // a one-cycle entry arriving at an empty queue launches straight away
      bypass       = push_i && (cnt_q == '0) && (push_entry_i.age == 3'd1);
      head_ready_o = bypass || ((cnt_q != '0) && (ent_q[rd_q].age == 3'd1));
      head_o       = bypass ? push_entry_i : ent_q[rd_q];
      store        = push_i && !(bypass && pop_i);
      deq          = pop_i && !bypass && (cnt_q != '0);

      ent_d = ent_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_d[i].age != 3'd0) begin
            ent_d[i].age = ent_d[i].age - 3'd1;
         end
      end
      if (store) begin
         ent_d[wr_q]     = push_entry_i;
         ent_d[wr_q].age = push_entry_i.age - 3'd1;
      end

      wr_d = store ? ptr_inc(wr_q) : wr_q;
      rd_d = deq ? ptr_inc(rd_q) : rd_q;

      cnt_d = cnt_q;
      case ({store, deq})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/obi_instr_mem_responder.sv
// OBI instruction memory responder: word RAM, grant logic, fixed-latency
// in-order responses. OBI_RESP_RANDOM_STALL_EN adds LFSR grant stalls.
module obi_instr_mem_responder
   import obi_resp_pkg::*;
#(
   parameter int unsigned MEM_WORDS       = 4096,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned RESP_LAT        = 1,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst,
   obi_instr_mem_responder_if.slave   bus,
   input  logic                       gnt_stall_i,
   input  logic                       load_we_i,
   input  logic [31:0]                load_addr_i,
   input  logic [31:0]                load_wdata_i,
   output logic                       busy_o
);

   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]   ram [MEM_WORDS];
   logic [CW-1:0] count_q, count_d;
   logic          rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          rand_stall;
   logic          gnt;
   logic          accept;
   range_t        fetch_rng;
   range_t        load_rng;
   resp_entry_t   push_entry;
   resp_entry_t   head;
   logic          head_ready;
   logic          unused_idx_bits;

`ifdef OBI_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rand_stall = (lfsr_q[1:0] == 2'b00);
`else
   logic unused_seed;
   assign unused_seed = ^LFSR_SEED;
   assign rand_stall  = 1'b0;
`endif

   assign unused_idx_bits = ^{fetch_rng.idx[29:AW], load_rng.idx[29:AW]};

   always_comb begin
      fetch_rng = in_range(bus.instr_addr_i, BASE_ADDR, 32'(MEM_WORDS));
      load_rng  = in_range(load_addr_i, BASE_ADDR, 32'(MEM_WORDS));

      // count is registered, so a retiring response never frees a slot early
      gnt    = bus.instr_req_i && (count_q < CW'(MAX_OUTSTANDING))
               && !gnt_stall_i && !rand_stall;
      accept = bus.instr_req_i && gnt;

      push_entry.rdata = fetch_rng.valid ? ram[fetch_rng.idx[AW-1:0]] : '0;
      push_entry.err   = !fetch_rng.valid;
      push_entry.age   = 3'(RESP_LAT);

      count_d = count_q;
      case ({accept, rvalid_q})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      rvalid_d = head_ready;
      rdata_d  = rdata_q;
      err_d    = err_q;
      if (head_ready) begin
         rdata_d = head.rdata;
         err_d   = head.err;
      end
   end

   // read happens combinationally above, so a same-cycle write sees old data
   always_ff @(posedge clk) begin
      if (load_we_i && load_rng.valid) begin
         ram[load_rng.idx[AW-1:0]] <= load_wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   obi_resp_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (accept),
      .push_entry_i (push_entry),
      .pop_i        (head_ready),
      .head_ready_o (head_ready),
      .head_o       (head)
   );

   assign bus.instr_gnt_o    = gnt;
   assign bus.instr_rvalid_o = rvalid_q;
   assign bus.instr_rdata_o  = rdata_q;
   assign bus.instr_err_o    = err_q;
   assign busy_o             = (count_q != '0);

endmodule

// File: tb/tb_obi_instr_mem_responder.sv
// Bench for obi_instr_mem_responder: two instances (LAT 1 and LAT 3)
// checked each cycle against a queue-of-due-times reference model.
module tb_obi_instr_mem_responder;

   localparam int unsigned LAT_A   = 1;
   localparam int unsigned LAT_B   = 3;
   localparam int unsigned MAXO_A  = 2;
   localparam int unsigned MAXO_B  = 2;
   localparam logic [31:0] BASE_A  = 32'h0000_0000;
   localparam logic [31:0] BASE_B  = 32'h0000_1000;
   localparam int unsigned WORDS_A = 4096;
   localparam int unsigned WORDS_B = 256;
   localparam int          NLOAD   = 64;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req   [2];
   logic [31:0] addr  [2];
   logic        stall [2];
   logic        we    [2];
   logic [31:0] laddr [2];
   logic [31:0] wdata [2];
   logic        gnt   [2];
   logic        rv    [2];
   logic        er    [2];
   logic [31:0] rd    [2];
   logic        busy  [2];

   exp_t        q [2][$];
   logic [31:0] mm [2][4096];
   logic [31:0] last_rd [2];
   logic        last_er [2];
   logic        lg [2];
   int          cyc;
   int          n_vec;
   int          n_bad;
   int          n_gnt [2];
   int          n_rvs [2];

   obi_instr_mem_responder_if ifa ();
   obi_instr_mem_responder_if ifb ();

   assign ifa.instr_req_i  = req[0];
   assign ifa.instr_addr_i = addr[0];
   assign ifb.instr_req_i  = req[1];
   assign ifb.instr_addr_i = addr[1];
   assign gnt[0] = ifa.instr_gnt_o;
   assign rv[0]  = ifa.instr_rvalid_o;
   assign rd[0]  = ifa.instr_rdata_o;
   assign er[0]  = ifa.instr_err_o;
   assign gnt[1] = ifb.instr_gnt_o;
   assign rv[1]  = ifb.instr_rvalid_o;
   assign rd[1]  = ifb.instr_rdata_o;
   assign er[1]  = ifb.instr_err_o;

   obi_instr_mem_responder #(
      .MEM_WORDS       (WORDS_A),
      .BASE_ADDR       (BASE_A),
      .MAX_OUTSTANDING (MAXO_A),
      .RESP_LAT        (LAT_A),
      .LFSR_SEED       (16'hACE1)
   ) dut_a (
      .clk          (clk),
      .rst          (rst),
      .bus          (ifa),
      .gnt_stall_i  (stall[0]),
      .load_we_i    (we[0]),
      .load_addr_i  (laddr[0]),
      .load_wdata_i (wdata[0]),
      .busy_o       (busy[0])
   );

   obi_instr_mem_responder #(
      .MEM_WORDS       (WORDS_B),
      .BASE_ADDR       (BASE_B),
      .MAX_OUTSTANDING (MAXO_B),
      .RESP_LAT        (LAT_B),
      .LFSR_SEED       (16'h1D2B)
   ) dut_b (
      .clk          (clk),
      .rst          (rst),
      .bus          (ifb),
      .gnt_stall_i  (stall[1]),
      .load_we_i    (we[1]),
      .load_addr_i  (laddr[1]),
      .load_wdata_i (wdata[1]),
      .busy_o       (busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p_lat(input int d);
      return (d == 0) ? int'(LAT_A) : int'(LAT_B);
   endfunction

   function automatic int p_maxo(input int d);
      return (d == 0) ? int'(MAXO_A) : int'(MAXO_B);
   endfunction

   function automatic logic [31:0] p_base(input int d);
      return (d == 0) ? BASE_A : BASE_B;
   endfunction

   function automatic longint p_words(input int d);
      return (d == 0) ? longint'(WORDS_A) : longint'(WORDS_B);
   endfunction

   function automatic logic ok_addr(input int d, input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(p_base(d));
      return (off >= 0) && ((off / 4) < p_words(d));
   endfunction

   function automatic int word_of(input int d, input logic [31:0] a);
      return int'((longint'(a) - longint'(p_base(d))) / 4);
   endfunction

   task automatic set_in(input int d, input logic r, input logic [31:0] a,
                         input logic s, input logic w,
                         input logic [31:0] la, input logic [31:0] wd);
      req[d]   = r;
      addr[d]  = a;
      stall[d] = s;
      we[d]    = w;
      laddr[d] = la;
      wdata[d] = wd;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         set_in(d, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
   endtask

   // one clock of both DUTs against the reference model; entered in low phase
   task automatic tick();
      exp_t n;
      logic exp_rv;
      logic exp_g;
      logic take;
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_rv = (q[d].size() != 0) && (q[d][0].due == cyc);
         n_vec++;
         if (rv[d] !== exp_rv) begin
            n_bad++;
            $display("FAIL rvalid[%0d] cyc %0d: got %b want %b", d, cyc, rv[d], exp_rv);
         end
         if (exp_rv) begin
            last_rd[d] = q[d][0].d;
            last_er[d] = q[d][0].e;
         end
         n_vec++;
         if (rd[d] !== last_rd[d] || er[d] !== last_er[d]) begin
            n_bad++;
            $display("FAIL rdata[%0d] cyc %0d: got %h/%b want %h/%b",
                     d, cyc, rd[d], er[d], last_rd[d], last_er[d]);
         end
         n_vec++;
         if (busy[d] !== (q[d].size() != 0)) begin
            n_bad++;
            $display("FAIL busy[%0d] cyc %0d: got %b want %b", d, cyc, busy[d], q[d].size() != 0);
         end
         exp_g = req[d] && (q[d].size() < p_maxo(d)) && !stall[d];
         n_vec++;
`ifdef OBI_RESP_RANDOM_STALL_EN
         if (gnt[d] === 1'b1 && !exp_g) begin
            n_bad++;
            $display("FAIL gnt[%0d] cyc %0d: got 1 want 0", d, cyc);
         end
         take = (gnt[d] === 1'b1);
`else
         if (gnt[d] !== exp_g) begin
            n_bad++;
            $display("FAIL gnt[%0d] cyc %0d: got %b want %b", d, cyc, gnt[d], exp_g);
         end
         take = exp_g;
`endif
         lg[d] = gnt[d];
         if (gnt[d] === 1'b1 && req[d]) n_gnt[d]++;
         if (rv[d] === 1'b1) n_rvs[d]++;
         if (take) begin
            n.e   = !ok_addr(d, addr[d]);
            n.d   = n.e ? 32'h0 : mm[d][word_of(d, addr[d])];
            n.due = cyc + p_lat(d);
            q[d].push_back(n);
         end
         if (exp_rv) void'(q[d].pop_front());
         if (we[d] && ok_addr(d, laddr[d])) mm[d][word_of(d, laddr[d])] = wdata[d];
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input int n);
      idle_all();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      #2;
      for (int d = 0; d < 2; d++) begin
         n_vec++;
         if (gnt[d] !== 1'b0 || rv[d] !== 1'b0 || rd[d] !== 32'h0
             || er[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state[%0d]: got g%b v%b d%h e%b b%b want all 0",
                     d, gnt[d], rv[d], rd[d], er[d], busy[d]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_preload();
      logic [31:0] v;
      for (int i = 0; i < NLOAD; i++) begin
         idle_all();
         for (int d = 0; d < 2; d++) begin
            v = $urandom;
            if (d == 0 && i == 0) v = 32'h0000_0013;
            if (d == 0 && i == 1) v = 32'h00A0_0093;
            if (d == 0 && i == 2) v = 32'h1111_1111;
            set_in(d, 1'b0, 32'h0, 1'b0, 1'b1, p_base(d) + 32'(i * 4), v);
         end
         tick();
      end
      // out-of-range writes that alias word 0 if wrongly accepted
      idle_all();
      set_in(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4000, 32'hBAD0_0000);
      set_in(1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1400, 32'hBAD0_0001);
      tick();
      set_in(1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0FFC, 32'hBAD0_0002);
      tick();
      drain(1);
   endtask

   task automatic test_fetch();
      idle_all();
      set_in(0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (rv[0] !== 1'b1 || rd[0] !== 32'h0000_0013 || er[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch0: got v%b %h e%b want v1 00000013 e0", rv[0], rd[0], er[0]);
      end
      set_in(0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (rv[0] !== 1'b1 || rd[0] !== 32'h00A0_0093 || er[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch1: got v%b %h e%b want v1 00a00093 e0", rv[0], rd[0], er[0]);
      end
      set_in(0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (rd[0] !== 32'h00A0_0093) begin
         n_bad++;
         $display("FAIL fetch_half: got %h want 00a00093", rd[0]);
      end
      drain(2);
   endtask

   task automatic test_outstanding();
      logic [7:0] seen;
      logic [7:0] want;
      want = 8'b0011_0011;
      idle_all();
      for (int i = 0; i < 8; i++) begin
         set_in(1, 1'b1, BASE_B + 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
         seen[i] = lg[1];
         n_vec++;
         if (busy[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL outstanding_busy cyc %0d: got %b want 1", i, busy[1]);
         end
      end
      n_vec++;
      if (seen !== want) begin
         n_bad++;
         $display("FAIL outstanding_gnt: got %b want %b", seen, want);
      end
      drain(6);
   endtask

   task automatic test_out_of_range();
      idle_all();
      set_in(0, 1'b1, BASE_A + 32'(WORDS_A * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      set_in(1, 1'b1, BASE_B + 32'(WORDS_B * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (rv[0] !== 1'b1 || er[0] !== 1'b1 || rd[0] !== 32'h0) begin
         n_bad++;
         $display("FAIL oor_a: got v%b e%b %h want v1 e1 0", rv[0], er[0], rd[0]);
      end
      set_in(0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
      set_in(1, 1'b1, BASE_B - 32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      idle_all();
      tick();
      n_vec++;
      if (rv[1] !== 1'b1 || er[1] !== 1'b1 || rd[1] !== 32'h0) begin
         n_bad++;
         $display("FAIL oor_b: got v%b e%b %h want v1 e1 0", rv[1], er[1], rd[1]);
      end
      drain(5);
   endtask

   task automatic test_rbw();
      idle_all();
      set_in(0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
      tick();
      n_vec++;
      if (rd[0] !== 32'h1111_1111) begin
         n_bad++;
         $display("FAIL rbw_old: got %h want 11111111", rd[0]);
      end
      set_in(0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (rd[0] !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL rbw_new: got %h want deadbeef", rd[0]);
      end
      drain(2);
   endtask

   task automatic test_reset_mid();
      idle_all();
      set_in(1, 1'b1, BASE_B, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      set_in(1, 1'b1, BASE_B + 32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      idle_all();
      tick();
      rst = 1'b1;
      #1;
      n_vec++;
      if (rv[1] !== 1'b0 || busy[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid: got v%b b%b want v0 b0", rv[1], busy[1]);
      end
      for (int d = 0; d < 2; d++) begin
         q[d].delete();
         last_rd[d] = 32'h0;
         last_er[d] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      drain(5);
      set_in(1, 1'b1, BASE_B + 32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      idle_all();
      tick();
      tick();
      n_vec++;
      if (rv[1] !== 1'b1 || rd[1] !== mm[1][2]) begin
         n_bad++;
         $display("FAIL reset_resume: got v%b %h want v1 %h", rv[1], rd[1], mm[1][2]);
      end
      drain(2);
   endtask

   task automatic test_stall();
      idle_all();
      for (int i = 0; i < 5; i++) begin
         set_in(0, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h0, 32'h0);
         tick();
         n_vec++;
         if (lg[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_gnt %0d: got %b want 0", i, lg[0]);
         end
      end
      drain(2);
   endtask

   function automatic logic [31:0] rand_addr(input int d);
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) begin
         return (d == 0) ? 32'h0000_4000 + 32'($urandom_range(0, 255) * 4)
                         : BASE_B - 32'($urandom_range(1, 16) * 4);
      end
      if (k == 1) return p_base(d) + 32'(p_words(d) * 4) + 32'($urandom_range(0, 63) * 4);
      return p_base(d) + 32'($urandom_range(0, NLOAD - 1) * 4) + 32'($urandom_range(0, 3));
   endfunction

   task automatic test_back_to_back();
      for (int d = 0; d < 2; d++) begin
         n_gnt[d] = 0;
         n_rvs[d] = 0;
      end
      for (int i = 0; i < 1000; i++) begin
         for (int d = 0; d < 2; d++) begin
            set_in(d, $urandom_range(0, 3) != 0, rand_addr(d),
                   $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                   rand_addr(d), $urandom);
         end
         tick();
      end
      drain(10);
      for (int d = 0; d < 2; d++) begin
         n_vec++;
         if (n_gnt[d] != n_rvs[d] || q[d].size() != 0) begin
            n_bad++;
            $display("FAIL count_match[%0d]: got %0d rvalid/%0d left want %0d/0",
                     d, n_rvs[d], q[d].size(), n_gnt[d]);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      cyc   = 0;
      for (int d = 0; d < 2; d++) begin
         last_rd[d] = 32'h0;
         last_er[d] = 1'b0;
         n_gnt[d]   = 0;
         n_rvs[d]   = 0;
      end
      idle_all();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      test_reset();
      test_preload();
      test_fetch();
      test_outstanding();
      test_out_of_range();
      test_rbw();
      test_reset_mid();
      test_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
